// File: rtl/rgb_pwm_pkg.sv
`default_nettype none
// ============================================================
// Package  : rgb_pwm_pkg
// Desc     : Mode/direction encodings and duty slicing helper
// Revision : 1.0
// ============================================================
package rgb_pwm_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_SOLID   = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    // Breathe envelope direction states
    localparam logic [0:0] c_dir_up   = 1'b0;
    localparam logic [0:0] c_dir_down = 1'b1;

    localparam int c_max_packed = 64;
    localparam int c_max_bits   = 16;

    // Extracts channel ch from a packed duty vector of bits-wide fields.
    function automatic logic [c_max_bits-1:0] duty_slice(
        input logic [c_max_packed-1:0] duty_vec,
        input int unsigned             ch,
        input int unsigned             bits
    );
        return c_max_bits'(duty_vec >> (ch * bits));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================
// Module   : pwm_channel
// Desc     : Per-channel breathe scaling and registered compare
// Revision : 1.0
// ============================================================
module pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic                i_enable,
    input  logic                i_breathe,
    input  logic [PWM_BITS-1:0] i_env,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_pwm
);

    logic [2*PWM_BITS-1:0] w_prod;
    logic [PWM_BITS-1:0]   w_scaled;
    logic [PWM_BITS-1:0]   w_eff;
    logic                  r_pwm;

    assign w_prod   = (2*PWM_BITS)'(i_duty) * (2*PWM_BITS)'(i_env);
    assign w_scaled = PWM_BITS'(w_prod >> PWM_BITS);

    always_comb begin
        w_eff = '0;
        if (i_enable) begin
            w_eff = i_breathe ? w_scaled : i_duty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (w_eff > i_pwm_cnt);
        end
    end

    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================
// Module   : rgb_pwm_ctrl
// Desc     : Multi-channel LED PWM controller for SB_RGBA_DRV
// Revision : 1.0
// ============================================================
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 64,
    parameter int BLINK_SHIFT = 5
) (
    input  logic                       hw_clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [NUM_CH*PWM_BITS-1:0] cfg_duty,
    input  logic [1:0]                 cfg_mode,
    output logic                       cfg_pending,
    output logic                       period_start,
    output logic [NUM_CH-1:0]          pwm_out
);

    localparam int c_ps_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_fr_w = (BLINK_SHIFT > 0) ? BLINK_SHIFT : 1;
    localparam logic [c_ps_w-1:0]   c_ps_max  = c_ps_w'(PRESCALE - 1);
    localparam logic [c_fr_w-1:0]   c_fr_max  = c_fr_w'((1 << BLINK_SHIFT) - 1);
    localparam logic [PWM_BITS-1:0] c_cnt_max = '1;

    logic [c_ps_w-1:0]          r_presc;
    logic [PWM_BITS-1:0]        r_cnt;
    logic                       r_period_start;
    logic                       r_pending;
    logic [NUM_CH*PWM_BITS-1:0] r_shadow_duty;
    logic [1:0]                 r_shadow_mode;
    logic [NUM_CH*PWM_BITS-1:0] r_act_duty;
    logic [1:0]                 r_act_mode;
    logic [c_fr_w-1:0]          r_frame;
    logic                       r_phase;
    logic [0:0]                 r_dir;
    logic [0:0]                 w_dir_nxt;
    logic [PWM_BITS-1:0]        r_env;
    logic [PWM_BITS-1:0]        w_env_nxt;

    logic                       w_step;
    logic                       w_wrap;
    logic                       w_apply;
    logic                       w_mode_chg;
    logic [NUM_CH*PWM_BITS-1:0] w_new_duty;
    logic [1:0]                 w_new_mode;
    logic                       w_ch_en;
    logic                       w_breathe;

    assign w_step     = (r_presc == c_ps_max);
    assign w_wrap     = w_step && (r_cnt == c_cnt_max);
    // A write landing on the wrap itself bypasses the shadow entirely.
    assign w_apply    = w_wrap && (cfg_we || r_pending);
    assign w_new_duty = cfg_we ? cfg_duty : r_shadow_duty;
    assign w_new_mode = cfg_we ? cfg_mode : r_shadow_mode;
    assign w_mode_chg = w_apply && (w_new_mode != r_act_mode);

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            r_presc        <= '0;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
            r_pending      <= 1'b0;
            r_shadow_duty  <= '0;
            r_shadow_mode  <= MODE_OFF;
            r_act_duty     <= '0;
            r_act_mode     <= MODE_OFF;
            r_frame        <= '0;
            r_phase        <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
            if (w_step) begin
                r_presc <= '0;
                r_cnt   <= r_cnt + PWM_BITS'(1);
            end else begin
                r_presc <= r_presc + c_ps_w'(1);
            end

            if (cfg_we) begin
                r_shadow_duty <= cfg_duty;
                r_shadow_mode <= cfg_mode;
            end
            if (w_wrap) begin
                r_pending <= 1'b0;
            end else if (cfg_we) begin
                r_pending <= 1'b1;
            end
            if (w_apply) begin
                r_act_duty <= w_new_duty;
                r_act_mode <= w_new_mode;
            end

            if (w_mode_chg) begin
                r_frame <= '0;
                r_phase <= 1'b0;
            end else if (w_wrap) begin
                r_frame <= (r_frame == c_fr_max) ? '0 : r_frame + c_fr_w'(1);
                if (r_frame == c_fr_max) begin
                    r_phase <= ~r_phase;
                end
            end
        end
    end

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            r_dir <= c_dir_up;
            r_env <= '0;
        end else begin
            r_dir <= w_dir_nxt;
            r_env <= w_env_nxt;
        end
    end

    always_comb begin
        w_dir_nxt = r_dir;
        w_env_nxt = r_env;
        if (w_mode_chg) begin
            w_dir_nxt = c_dir_up;
            w_env_nxt = '0;
        end else if (w_wrap) begin
            case (r_dir)
                c_dir_up: begin
                    if (r_env == c_cnt_max) begin
                        w_dir_nxt = c_dir_down;
                        w_env_nxt = r_env - PWM_BITS'(1);
                    end else begin
                        w_env_nxt = r_env + PWM_BITS'(1);
                    end
                end
                default: begin
                    if (r_env == '0) begin
                        w_dir_nxt = c_dir_up;
                        w_env_nxt = r_env + PWM_BITS'(1);
                    end else begin
                        w_env_nxt = r_env - PWM_BITS'(1);
                    end
                end
            endcase
        end
    end

    assign w_ch_en   = (r_act_mode != MODE_OFF) && !((r_act_mode == MODE_BLINK) && r_phase);
    assign w_breathe = (r_act_mode == MODE_BREATHE);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [PWM_BITS-1:0] w_duty;
        assign w_duty = PWM_BITS'(duty_slice(c_max_packed'(r_act_duty), gi, PWM_BITS));

        pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (hw_clk),
            .rst       (rst),
            .i_duty    (w_duty),
            .i_enable  (w_ch_en),
            .i_breathe (w_breathe),
            .i_env     (r_env),
            .i_pwm_cnt (r_cnt),
            .o_pwm     (pwm_out[gi])
        );
    end

    assign cfg_pending  = r_pending;
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================
// Module   : tb_rgb_pwm_ctrl
// Desc     : Scoreboard bench counting per-period high clocks
// Revision : 1.0
// ============================================================
module tb_rgb_pwm_ctrl;

    localparam int NUM_CH      = 3;
    localparam int PWM_BITS    = 4;
    localparam int PRESCALE    = 1;
    localparam int BLINK_SHIFT = 1;

    localparam logic [1:0] M_SOLID   = 2'b01;
    localparam logic [1:0] M_BLINK   = 2'b10;
    localparam logic [1:0] M_BREATHE = 2'b11;

    logic        hw_clk = 1'b0;
    logic        rst    = 1'b1;
    logic        cfg_we = 1'b0;
    logic [11:0] cfg_duty = '0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_pending;
    logic        period_start;
    logic [2:0]  pwm_out;

    always #5 hw_clk = ~hw_clk;

    rgb_pwm_ctrl #(
        .NUM_CH      (NUM_CH),
        .PWM_BITS    (PWM_BITS),
        .PRESCALE    (PRESCALE),
        .BLINK_SHIFT (BLINK_SHIFT)
    ) dut (
        .hw_clk       (hw_clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_duty     (cfg_duty),
        .cfg_mode     (cfg_mode),
        .cfg_pending  (cfg_pending),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    typedef struct {
        int r;
        int g;
        int b;
    } exp_t;

    exp_t  q[$];
    exp_t  e_mon;
    int    n_vec = 0;
    int    n_err = 0;
    int    n_per = 0;
    bit    mon_en = 1'b0;
    int    acc_r, acc_g, acc_b;
    string tag = "init";

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0d, expected %0d", tag, name, act, exp);
        end
    endfunction

    task automatic fail_now(string name);
        n_vec++;
        n_err++;
        $display("FAIL %s/%s: bound expired", tag, name);
    endtask

    task automatic push(int r, int g, int b);
        exp_t e;
        e.r = r;
        e.g = g;
        e.b = b;
        q.push_back(e);
    endtask

    // Per-period monitor: the sample taken on a period_start cycle still
    // belongs to the period just ended (compare output lags pwm_cnt by 1).
    initial begin
        forever begin
            @(negedge hw_clk);
            if (rst) begin
                acc_r = 0;
                acc_g = 0;
                acc_b = 0;
            end else begin
                acc_r = acc_r + (pwm_out[0] ? 1 : 0);
                acc_g = acc_g + (pwm_out[1] ? 1 : 0);
                acc_b = acc_b + (pwm_out[2] ? 1 : 0);
                if (period_start) begin
                    if (mon_en) begin
                        n_per++;
                        if (q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL %s/unexpected_period %0d: no expectation queued", tag, n_per);
                        end else begin
                            e_mon = q.pop_front();
                            check($sformatf("p%0d_red_high", n_per), acc_r, e_mon.r);
                            check($sformatf("p%0d_green_high", n_per), acc_g, e_mon.g);
                            check($sformatf("p%0d_blue_high", n_per), acc_b, e_mon.b);
                        end
                    end
                    acc_r = 0;
                    acc_g = 0;
                    acc_b = 0;
                end
            end
        end
    end

    task automatic apply_reset();
        mon_en = 1'b0;
        cfg_we = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge hw_clk);
        n_per = 0;
    endtask

    task automatic write_cfg(int r, int g, int b, logic [1:0] m);
        logic [3:0] lr, lg, lb;
        lr = 4'(r);
        lg = 4'(g);
        lb = 4'(b);
        cfg_duty = {lb, lg, lr};
        cfg_mode = m;
        cfg_we   = 1'b1;
        @(negedge hw_clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_ps();
        int k;
        k = 0;
        do begin
            @(negedge hw_clk);
            k++;
        end while (!period_start && k < 64);
        if (!period_start) fail_now("wait_period_start");
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 2000) begin
            @(negedge hw_clk);
            k++;
        end
        if (q.size() != 0) fail_now("scoreboard_drain");
        mon_en = 1'b0;
        q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int env;

        // Reset state and first period_start timing
        tag = "reset";
        apply_reset();
        check("pwm_out_in_reset", int'(pwm_out), 0);
        check("pending_in_reset", int'(cfg_pending), 0);
        check("period_start_in_reset", int'(period_start), 0);
        push(0, 0, 0);
        mon_en = 1'b1;
        rst = 1'b0;
        k = 0;
        do begin
            @(negedge hw_clk);
            k++;
        end while (!period_start && k < 40);
        check("clocks_to_first_period_start", k, 16);
        wait_drain();

        // SOLID with three distinct duties
        tag = "solid";
        apply_reset();
        push(0, 0, 0);
        push(4, 0, 15);
        push(4, 0, 15);
        mon_en = 1'b1;
        rst = 1'b0;
        write_cfg(4, 0, 15, M_SOLID);
        check("pending_after_write", int'(cfg_pending), 1);
        wait_ps();
        check("pending_after_wrap", int'(cfg_pending), 0);
        wait_drain();

        // Asynchronous reset mid-period, with a write pending
        tag = "mid_reset";
        wait_ps();
        write_cfg(9, 9, 9, M_SOLID);
        check("pwm_out_before_reset", int'(pwm_out), 5);
        check("pending_before_reset", int'(cfg_pending), 1);
        #2 rst = 1'b1;
        #1;
        check("pwm_out_async_reset", int'(pwm_out), 0);
        check("pending_async_reset", int'(cfg_pending), 0);

        // Shadow last-write-wins, and a write on the wrap cycle
        tag = "shadow";
        apply_reset();
        push(0, 0, 0);
        push(4, 0, 0);
        push(2, 0, 0);
        push(6, 0, 0);
        mon_en = 1'b1;
        rst = 1'b0;
        write_cfg(4, 0, 0, M_SOLID);
        wait_ps();
        repeat (4) @(negedge hw_clk);
        write_cfg(8, 0, 0, M_SOLID);
        repeat (3) @(negedge hw_clk);
        write_cfg(2, 0, 0, M_SOLID);
        check("pending_after_two_writes", int'(cfg_pending), 1);
        wait_ps();
        repeat (15) @(negedge hw_clk);
        write_cfg(6, 0, 0, M_SOLID);
        check("wrap_cycle_period_start", int'(period_start), 1);
        check("wrap_cycle_pending", int'(cfg_pending), 0);
        @(negedge hw_clk);
        check("wrap_cycle_pending_next", int'(cfg_pending), 0);
        wait_drain();

        // BLINK: two periods on, two off
        tag = "blink";
        apply_reset();
        push(0, 0, 0);
        push(8, 0, 0);
        push(8, 0, 0);
        push(0, 0, 0);
        push(0, 0, 0);
        push(8, 0, 0);
        push(8, 0, 0);
        push(0, 0, 0);
        mon_en = 1'b1;
        rst = 1'b0;
        write_cfg(8, 0, 0, M_BLINK);
        wait_drain();

        // BREATHE: full triangle plus turnarounds at 15 and 0
        tag = "breathe";
        apply_reset();
        push(0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            env = (i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30);
            push((15 * env) >> 4, 0, 0);
        end
        mon_en = 1'b1;
        rst = 1'b0;
        write_cfg(15, 0, 0, M_BREATHE);
        wait_drain();

        // BREATHE -> SOLID -> BREATHE restarts the envelope
        tag = "breathe_restart";
        apply_reset();
        push(0, 0, 0);
        push(0, 0, 0);
        push(0, 0, 0);
        push(1, 0, 0);
        push(2, 0, 0);
        push(3, 0, 0);
        push(15, 0, 0);
        push(0, 0, 0);
        push(0, 0, 0);
        push(1, 0, 0);
        push(2, 0, 0);
        push(3, 0, 0);
        mon_en = 1'b1;
        rst = 1'b0;
        write_cfg(15, 0, 0, M_BREATHE);
        repeat (5) wait_ps();
        repeat (4) @(negedge hw_clk);
        write_cfg(15, 0, 0, M_SOLID);
        wait_ps();
        repeat (4) @(negedge hw_clk);
        write_cfg(15, 0, 0, M_BREATHE);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
